// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-high hex font,
// blank pattern and parameter legality limits.
package seg_pkg;
   localparam int NUM_DIGITS_MIN = 1;
   localparam int NUM_DIGITS_MAX = 8;
   localparam int SCAN_LOG2_MIN  = 4;
   localparam int SCAN_LOG2_MAX  = 24;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Index = nibble value; bit 0 = segment a, bit 6 = segment g.
   localparam logic [15:0][6:0] HEX_FONT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };
endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-high seven-segment pattern.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   assign seg = HEX_FONT[nibble];
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with per-frame input shadowing,
// PWM brightness via dwell-counter MSBs and optional leading-zero blanking.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_LOG2  = 17,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [3:0]              bright,
   input  logic                    lzb,
   output logic [6:0]              seg,
   output logic                    seg_dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);
   localparam int                   DW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SCAN_LOG2-1:0] CNT_MAX  = '1;
   localparam logic [DW-1:0]        DIG_LAST = DW'(NUM_DIGITS - 1);
   localparam logic                 POL      = (ACTIVE_LOW != 0);

   if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX ||
       SCAN_LOG2 < SCAN_LOG2_MIN || SCAN_LOG2 > SCAN_LOG2_MAX) begin : g_bad_param
      $error("seg_scan_driver: NUM_DIGITS or SCAN_LOG2 out of range");
   end

   logic [SCAN_LOG2-1:0] cnt;
   logic [DW-1:0]        dig;
   logic                 frame_start;
   logic                 dwell_end;

   assign frame_start = enable && (cnt == '0) && (dig == '0);
   assign dwell_end   = (cnt == CNT_MAX);
   assign frame_done  = !rst && enable && dwell_end && (dig == DIG_LAST);

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         cnt <= '0;
         dig <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         if (dwell_end)
            dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
      end
   end

   // Inputs are frozen for the whole frame so a digit never shows torn data.
   logic [NUM_DIGITS-1:0][3:0] sh_data;
   logic [NUM_DIGITS-1:0]      sh_dp;
   logic [3:0]                 sh_bright;
   logic                       sh_lzb;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_data   <= '0;
         sh_dp     <= '0;
         sh_bright <= '0;
         sh_lzb    <= 1'b0;
      end else if (frame_start) begin
         sh_data   <= data;
         sh_dp     <= dp;
         sh_bright <= bright;
         sh_lzb    <= lzb;
      end
   end

   // Stage 1 captures scan position so stage 2 sees shadows loaded at frame start.
   logic          s1_vld;
   logic [DW-1:0] s1_dig;
   logic [3:0]    s1_lvl;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1_dig <= '0;
         s1_lvl <= '0;
      end else begin
         s1_vld <= enable;
         s1_dig <= dig;
         s1_lvl <= cnt[SCAN_LOG2-1 -: 4];
      end
   end

   logic [NUM_DIGITS-1:0] blank;
   logic                  lz_run;

   always_comb begin
      blank  = '0;
      lz_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz_run   = lz_run & (sh_data[i] == 4'h0);
         blank[i] = sh_lzb & lz_run;
      end
   end

   logic [6:0] dec_seg;

   seg_hex_decode u_dec (
      .nibble (sh_data[s1_dig]),
      .seg    (dec_seg)
   );

   logic [6:0]            seg_nxt;
   logic                  dp_nxt;
   logic [NUM_DIGITS-1:0] an_nxt;

   always_comb begin
      seg_nxt = SEG_BLANK;
      dp_nxt  = 1'b0;
      an_nxt  = '0;
      if (s1_vld) begin
         seg_nxt = blank[s1_dig] ? SEG_BLANK : dec_seg;
         dp_nxt  = sh_dp[s1_dig];
         if (s1_lvl <= sh_bright)
            an_nxt[s1_dig] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg    <= {7{POL}};
         seg_dp <= POL;
         an     <= {NUM_DIGITS{POL}};
      end else begin
         seg    <= seg_nxt ^ {7{POL}};
         seg_dp <= dp_nxt ^ POL;
         an     <= an_nxt ^ {NUM_DIGITS{POL}};
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 16-cycle dwell, active-low pins).
module tb_seg_scan_driver;
   logic        clk = 1'b0;
   logic        rst, enable, lzb;
   logic [15:0] data;
   logic [3:0]  dp, bright;
   logic [6:0]  seg;
   logic        seg_dp;
   logic [3:0]  an;
   logic        frame_done;

   always #5 clk = ~clk;

   seg_scan_driver #(.NUM_DIGITS(4), .SCAN_LOG2(4), .ACTIVE_LOW(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .data       (data),
      .dp         (dp),
      .bright     (bright),
      .lzb        (lzb),
      .seg        (seg),
      .seg_dp     (seg_dp),
      .an         (an),
      .frame_done (frame_done)
   );

   // Pin-level (active-low) segment patterns per digit, {d3, d2, d1, d0}.
   typedef struct {
      logic [15:0]     data;
      logic [3:0]      dp;
      logic [3:0]      bright;
      logic            lzb;
      logic [3:0][6:0] seg_pin;
   } vec_t;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] an;
   } exp_t;

   localparam exp_t OFF = {7'h7F, 1'b1, 4'hF};

   vec_t tbl [7];
   exp_t sb [$];
   int   total = 0;
   int   bad   = 0;
   int   m_cnt = 0, m_dig = 0, m_sh = 0;
   int   fd_seen = 0;
   int   fd0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input int idx);
      exp_t       ex;
      logic [3:0] oh;
      @(negedge clk);
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty at %0t: got=0 want=1", $time);
      end else begin
         ex = sb.pop_front();
         chk("seg", {9'd0, seg}, {9'd0, ex.seg});
         chk("seg_dp", {15'd0, seg_dp}, {15'd0, ex.dp});
         chk("an", {12'd0, an}, {12'd0, ex.an});
      end
      rst    = r;
      enable = e;
      data   = tbl[idx].data;
      dp     = tbl[idx].dp;
      bright = tbl[idx].bright;
      lzb    = tbl[idx].lzb;
      #1;
      chk("frame_done", {15'd0, frame_done},
          {15'd0, (!r && e && m_cnt == 15 && m_dig == 3)});
      if (frame_done) fd_seen++;
      if (r || !e) begin
         ex    = OFF;
         m_cnt = 0;
         m_dig = 0;
         // reset also clears the output register one cycle sooner
         if (r && sb.size() > 0) sb[sb.size()-1] = OFF;
      end else begin
         if (m_cnt == 0 && m_dig == 0) m_sh = idx;
         oh     = 4'b0001 << m_dig;
         ex.seg = tbl[m_sh].seg_pin[m_dig];
         ex.dp  = ~tbl[m_sh].dp[m_dig];
         ex.an  = (m_cnt <= int'(tbl[m_sh].bright)) ? ~oh : 4'hF;
         m_cnt++;
         if (m_cnt == 16) begin
            m_cnt = 0;
            m_dig = (m_dig + 1) % 4;
         end
      end
      sb.push_back(ex);
   endtask

   initial begin
      tbl[0] = '{data:16'h1234, dp:4'h0, bright:4'hF, lzb:1'b0, seg_pin:{7'h79, 7'h24, 7'h30, 7'h19}};
      tbl[1] = '{data:16'hABCD, dp:4'h5, bright:4'hF, lzb:1'b0, seg_pin:{7'h08, 7'h03, 7'h46, 7'h21}};
      tbl[2] = '{data:16'h0050, dp:4'h0, bright:4'hF, lzb:1'b1, seg_pin:{7'h7F, 7'h7F, 7'h12, 7'h40}};
      tbl[3] = '{data:16'h0000, dp:4'hF, bright:4'hF, lzb:1'b1, seg_pin:{7'h7F, 7'h7F, 7'h7F, 7'h40}};
      tbl[4] = '{data:16'h1234, dp:4'h8, bright:4'h3, lzb:1'b0, seg_pin:{7'h79, 7'h24, 7'h30, 7'h19}};
      tbl[5] = '{data:16'h00F0, dp:4'h2, bright:4'h7, lzb:1'b0, seg_pin:{7'h40, 7'h40, 7'h0E, 7'h40}};
      tbl[6] = '{data:16'h8090, dp:4'h0, bright:4'h0, lzb:1'b1, seg_pin:{7'h00, 7'h40, 7'h10, 7'h40}};

      rst = 1'b1; enable = 1'b0; data = '0; dp = '0; bright = '0; lzb = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", {12'd0, an}, 16'h000F);
      chk("rst_seg", {9'd0, seg}, 16'h007F);
      chk("rst_seg_dp", {15'd0, seg_dp}, 16'h0001);
      chk("rst_frame_done", {15'd0, frame_done}, 16'h0000);
      sb.push_back(OFF);
      sb.push_back(OFF);

      // two full frames of 1234: one frame_done per 64 cycles
      fd0 = fd_seen;
      repeat (128) step(1'b0, 1'b1, 0);
      chk("fd_two_frames", 16'(fd_seen - fd0), 16'd2);

      for (int k = 0; k < 7; k++) begin
         fd0 = fd_seen;
         repeat (64) step(1'b0, 1'b1, k);
         chk("fd_per_vector", 16'(fd_seen - fd0), 16'd1);
      end

      // data change at cnt=5 of digit 1 stays hidden until next frame
      repeat (21) step(1'b0, 1'b1, 0);
      repeat (43) step(1'b0, 1'b1, 1);
      repeat (64) step(1'b0, 1'b1, 1);

      // enable dropped during digit 2, then restarted with new data
      repeat (39) step(1'b0, 1'b1, 0);
      fd0 = fd_seen;
      repeat (3) step(1'b0, 1'b0, 1);
      chk("an_off_after_drop", {12'd0, an}, 16'h000F);
      repeat (7) step(1'b0, 1'b0, 1);
      chk("fd_while_disabled", 16'(fd_seen - fd0), 16'd0);
      repeat (64) step(1'b0, 1'b1, 1);

      // reset mid-frame abandons the frame
      repeat (40) step(1'b0, 1'b1, 0);
      fd0 = fd_seen;
      repeat (2) step(1'b1, 1'b1, 0);
      repeat (64) step(1'b0, 1'b1, 4);
      chk("fd_after_mid_reset", 16'(fd_seen - fd0), 16'd1);

      repeat (2) step(1'b0, 1'b1, 4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
